// File: rtl/ts_clkdiv_mc.sv
// ts_clkdiv_mc: multi-channel programmable clock divider with glitch-free reload.
// Optional TS_CLKDIV_PULSE_EN adds the per-channel pulse_out strobe.
module ts_clkdiv_mc #(
  parameter int NUM_CH      = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int DIV_DEFAULT = 4
) (
  input  logic                        clk2,
  input  logic                        rst,
  input  logic [NUM_CH*DIV_WIDTH-1:0] div_in,
  input  logic [NUM_CH-1:0]           load,
  input  logic [NUM_CH-1:0]           enable,
  input  logic                        sync,
  output logic [NUM_CH-1:0]           clk_out
`ifdef TS_CLKDIV_PULSE_EN
  ,
  output logic [NUM_CH-1:0]           pulse_out
`endif
);

  localparam logic [DIV_WIDTH-1:0] D_TWO = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] D_RST =
    (DIV_DEFAULT < 2) ? D_TWO : DIV_WIDTH'(DIV_DEFAULT);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIV_WIDTH-1:0] raw;
    logic [DIV_WIDTH-1:0] d_ld;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] dact_q, dact_d;
    logic [DIV_WIDTH-1:0] dpend_q, dpend_d;
    logic [DIV_WIDTH-1:0] half;
    logic                 pend_q, pend_d;
    logic                 run_q, run_d;
    logic                 clk_q, clk_d;

    assign raw  = div_in[c*DIV_WIDTH +: DIV_WIDTH];
    assign d_ld = (raw < D_TWO) ? D_TWO : raw;

    always_comb begin
      cnt_d   = cnt_q;
      dact_d  = dact_q;
      dpend_d = dpend_q;
      pend_d  = pend_q;
      run_d   = enable[c];
      if (!enable[c]) begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (load[c])
          dact_d = d_ld;
        else if (pend_q)
          dact_d = dpend_q;
      end else if (!run_q) begin
        cnt_d = '0;
        if (load[c])
          dact_d = d_ld;
      end else if (sync || (cnt_q == dact_q - 1'b1)) begin
        // period boundary: newest ratio wins
        cnt_d  = '0;
        pend_d = 1'b0;
        if (load[c])
          dact_d = d_ld;
        else if (pend_q)
          dact_d = dpend_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (load[c]) begin
          dpend_d = d_ld;
          pend_d  = 1'b1;
        end
      end
      half  = (dact_d >> 1) + {{(DIV_WIDTH-1){1'b0}}, dact_d[0]};
      clk_d = run_d && (cnt_d < half);
    end

    always_ff @(posedge clk2) begin
      if (rst) begin
        cnt_q   <= '0;
        dact_q  <= D_RST;
        dpend_q <= D_RST;
        pend_q  <= 1'b0;
        run_q   <= 1'b0;
        clk_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        dact_q  <= dact_d;
        dpend_q <= dpend_d;
        pend_q  <= pend_d;
        run_q   <= run_d;
        clk_q   <= clk_d;
      end
    end

    assign clk_out[c] = clk_q;

`ifdef TS_CLKDIV_PULSE_EN
    logic pls_q, pls_d;
    assign pls_d = run_d && (cnt_d == '0);

    always_ff @(posedge clk2) begin
      if (rst)
        pls_q <= 1'b0;
      else
        pls_q <= pls_d;
    end

    assign pulse_out[c] = pls_q;
`endif
  end

endmodule

// File: tb/tb_ts_clkdiv_mc.sv
// tb_ts_clkdiv_mc: directed self-checking bench for ts_clkdiv_mc.
// Pulse checks are active when TS_CLKDIV_PULSE_EN is defined.
module tb_ts_clkdiv_mc;

  logic        clk2 = 1'b0;
  logic        rst;
  logic [15:0] div_in;
  logic [1:0]  load;
  logic [1:0]  enable;
  logic        sync;
  logic [1:0]  clk_out;
`ifdef TS_CLKDIV_PULSE_EN
  logic [1:0]  pulse_out;
`endif

  int checks = 0;
  int failures = 0;

  ts_clkdiv_mc dut (
    .clk2      (clk2),
    .rst       (rst),
    .div_in    (div_in),
    .load      (load),
    .enable    (enable),
    .sync      (sync),
    .clk_out   (clk_out)
`ifdef TS_CLKDIV_PULSE_EN
    ,
    .pulse_out (pulse_out)
`endif
  );

  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(string tag, logic [1:0] c, logic [1:0] p);
    chk({tag, ".clk"}, 32'(clk_out), 32'(c));
`ifdef TS_CLKDIV_PULSE_EN
    chk({tag, ".pls"}, 32'(pulse_out), 32'(p));
`else
    if (p === 2'bxx) $display("unused");
`endif
  endtask

  // channel ch, cnt=0 observed now; step n cycles of ratio d
  task automatic wave(string tag, int ch, int d, int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk({tag, ".clk"}, 32'(clk_out[ch]),
          32'((i % d) < (d + 1) / 2));
`ifdef TS_CLKDIV_PULSE_EN
      chk({tag, ".pls"}, 32'(pulse_out[ch]),
          32'((i % d) == 0));
`endif
    end
  endtask

  task automatic both(string tag, int d0, int d1, int n);
    logic [1:0] c, p;
    for (int i = 1; i <= n; i++) begin
      tick();
      c = {1'((i % d1) < (d1 + 1) / 2),
           1'((i % d0) < (d0 + 1) / 2)};
      p = {1'((i % d1) == 0), 1'((i % d0) == 0)};
      chk_out(tag, c, p);
    end
  endtask

  task automatic start0(string tag, logic [7:0] d);
    enable = 2'b00;
    tick();
    chk_out({tag, ".stop"}, 2'b00, 2'b00);
    div_in[7:0] = d;
    load = 2'b01;
    tick();
    load = 2'b00;
    enable = 2'b01;
    tick();
    chk_out({tag, ".start"}, 2'b01, 2'b01);
  endtask

  initial begin
    rst = 1'b1;
    div_in = '0;
    load = '0;
    enable = '0;
    sync = 1'b0;
    tick();
    tick();
    chk_out("reset", 2'b00, 2'b00);

    // default ratio 4 on both channels
    rst = 1'b0;
    enable = 2'b11;
    tick();
    chk_out("def.start", 2'b11, 2'b11);
    both("def4", 4, 4, 8);

    // odd and clamped ratios
    start0("d5", 8'd5);
    wave("d5", 0, 5, 10);
    start0("d0", 8'd0);
    wave("d0", 0, 2, 6);
    start0("d1", 8'd1);
    wave("d1", 0, 2, 6);

    // reload: 6 then 8 before wrap, then 6 on the wrap edge
    start0("rl", 8'd4);
    tick();
    chk("rl.c1", 32'(clk_out[0]), 32'd1);
    div_in[7:0] = 8'd6;
    load = 2'b01;
    tick();
    chk("rl.c2", 32'(clk_out[0]), 32'd0);
    div_in[7:0] = 8'd8;
    tick();
    load = 2'b00;
    chk("rl.c3", 32'(clk_out[0]), 32'd0);
    tick();
    chk_out("rl.wrap4", 2'b01, 2'b01);
    wave("rl8", 0, 8, 7);
    div_in[7:0] = 8'd6;
    load = 2'b01;
    tick();
    load = 2'b00;
    chk_out("rl.wrap8", 2'b01, 2'b01);
    wave("rl6", 0, 6, 6);

    // sync two offset channels at 4 and 6
    enable = 2'b00;
    tick();
    div_in = {8'd6, 8'd4};
    load = 2'b11;
    tick();
    load = 2'b00;
    enable = 2'b01;
    tick();
    tick();
    tick();
    enable = 2'b11;
    tick();
    chk_out("off", 2'b10, 2'b10);
    tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk_out("sync", 2'b11, 2'b11);
    both("sync46", 4, 6, 12);

    // stop mid high phase, idle sync, restart
    enable = 2'b00;
    tick();
    chk_out("stop", 2'b00, 2'b00);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk_out("idlesync", 2'b00, 2'b00);
    enable = 2'b11;
    tick();
    chk_out("restart", 2'b11, 2'b11);
    both("re46", 4, 6, 7);

    // reset mid-period with enable high
    rst = 1'b1;
    tick();
    chk_out("rst1", 2'b00, 2'b00);
    tick();
    chk_out("rst2", 2'b00, 2'b00);
    rst = 1'b0;
    tick();
    chk_out("rst.re", 2'b11, 2'b11);
    both("rst44", 4, 4, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ts_clkdiv_mc.md
# ts_clkdiv_mc

Multi-channel, runtime-programmable clock divider for the MPEG2-TS QoS datapath. From a single fast clock it generates NUM_CH independent divided square waves and matching one-cycle enable pulses, such as 27 MHz PCR/STC ticks and byte-rate strobes. Each channel has its own divide ratio, enable, and glitch-free ratio reload. A global sync input phase-aligns all channels. The default configuration reproduces the fixed 108→27 MHz divide-by-4.

## Interface
Parameters:
- NUM_CH, 2, number of independent output channels (≥1)
- DIV_WIDTH, 8, width of each channel's divide ratio
- DIV_DEFAULT, 4, divide ratio loaded into every channel at reset (clamped to ≥2)

Ports:
- clk2  in  1  system clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- div_in  in  NUM_CH*DIV_WIDTH  per-channel requested ratio D; channel c at [c*DIV_WIDTH +: DIV_WIDTH]
- load  in  NUM_CH  per-channel strobe; captures the channel's div_in slice
- enable  in  NUM_CH  per-channel run enable (level)
- sync  in  1  restart all running channels at phase 0
- clk_out  out  NUM_CH  divided square wave per channel, registered
- pulse_out  out  NUM_CH  one-clk2-cycle pulse at each clk_out rising edge, registered (present only with TS_CLKDIV_PULSE_EN)

## Operation
Per-channel state:
- cnt[DIV_WIDTH]: phase counter
- d_act: active ratio
- d_pend and pend flag: pending ratio
- run flag: registered enable

Ratio handling:
- Effective ratio is max(D, 2). Both D=0 and D=1 are clamped to 2.
- Period is d_act clk2 cycles.
- High time is ceil(d_act/2) cycles and low time is floor(d_act/2) cycles. Odd ratios therefore give the longer high phase.

Running channel:
- cnt advances 0…d_act−1, then wraps to 0.
- clk_out = (cnt < ceil(d_act/2)).
- pulse_out = (cnt == 0).
- Both outputs are registered and derived from the next-state cnt, so they change on the same edge as cnt.

Enable:
- Rising enable starts the channel with cnt=0. clk_out and pulse_out go high on that same edge.
- When enable is sampled low, at the next edge run=0, cnt=0, and clk_out=pulse_out=0. This is an immediate stop; a truncated high phase is permitted.

Ratio reload (load):
- Running channel: the clamped div_in is written to d_pend and pend is set. At the wrap edge (cnt==d_act−1) d_act takes d_pend and pend clears, so the new period starts with the new ratio.
- Idle channel: d_act is written directly.
- A second load while pend is set overwrites d_pend.
- If load coincides with the wrap edge, the newly loaded value is the one applied at that wrap.

Sync:
- On the next edge every running channel sets cnt=0, applies any pending ratio, and drives outputs high.
- Idle channels ignore sync.

Priority: rst > enable low > sync > wrap/increment.

## Timing
- Reset values:
  - clk_out=0, pulse_out=0, cnt=0, run=0, pend=0
  - d_act = max(DIV_DEFAULT, 2)
- Start latency: enable sampled high at edge k → outputs high after edge k. The first pulse coincides with the first high phase.
- Stop latency: one edge.
- Reload latency: takes effect at the first wrap after load, at most d_act cycles later.
- sync latency: one edge.
- A reset asserted mid-period overrides everything on that edge; after reset deasserts, a channel whose enable is already high restarts at the next edge.
- With d_act=2, clk_out toggles every cycle and pulse_out is high every other cycle.
- Counter width is DIV_WIDTH, so the maximum ratio is 2^DIV_WIDTH−1 with no overflow.

## Configuration
- TS_CLKDIV_PULSE_EN defined: the pulse_out port and its registers exist as specified.
- TS_CLKDIV_PULSE_EN undefined: the pulse_out port is absent and clk_out behaviour is unchanged.

## Test plan
- Default parameters, rst then enable=2'b11: each clk_out is a period-4 wave (2 high / 2 low) and pulse_out fires every 4th cycle, aligned with the clk_out rise.
- Channel 0 D=5: 3 high / 2 low. D=0 and D=1 behave as D=2, toggling every cycle.
- Channel 0 running with D=4, load D=6 at cnt=1: the current period completes at 4 cycles and the next period is 6 (3/3). A second load of 8 before the wrap overrides it, so the next period is 8.
- Channels at D=4 and D=6, offset in phase, pulse sync: both have cnt=0 and clk_out high after the next edge, and the pulses coincide every 12 cycles.
- Deassert enable during the high phase: outputs are 0 on the next edge. Re-enable: the first edge gives clk_out=1 and pulse_out=1.
- Assert rst mid-period with enable high: outputs are 0 during reset and d_act reverts to DIV_DEFAULT. Compile without TS_CLKDIV_PULSE_EN and confirm clk_out is identical.
